protect_checker: RTL and testbench

PROTECT_CHECKER -- requirements
Module: protect_checker

---
 rtl/protect_checker.sv | 119 +++++++++++
 tb/tb_protect_checker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/protect_checker.sv
// Address-range protection checker: four configurable regions, registered
// violation decision, IDLE/FAULT report handshake and a saturating counter.
module protect_checker #(
    parameter int BUS_WIDTH = 32,
    parameter int REGIONS   = 4
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_region,
    input  logic [BUS_WIDTH-1:0] cfg_base,
    input  logic [BUS_WIDTH-1:0] cfg_limit,
    input  logic                 cfg_enable,
    input  logic                 cfg_rdprot,
    input  logic                 bus_valid,
    input  logic                 bus_write,
    input  logic [BUS_WIDTH-1:0] bus_addr,
    input  logic                 fault_ack,
    output logic                 violation_set,
    output logic [BUS_WIDTH-1:0] violation_addr,
    output logic                 violation_write,
    output logic                 fault_pending,
    output logic [7:0]           violation_count
);

    typedef enum logic {IDLE, FAULT} state_t;

    state_t               state_reg, state_next;
    logic [BUS_WIDTH-1:0] base_reg  [REGIONS];
    logic [BUS_WIDTH-1:0] limit_reg [REGIONS];
    logic [REGIONS-1:0]   enable_reg;
    logic [REGIONS-1:0]   rdprot_reg;
    logic                 set_reg, set_next;
    logic [BUS_WIDTH-1:0] addr_reg, addr_next;
    logic                 write_reg, write_next;
    logic [7:0]           count_reg, count_next;
    logic [REGIONS-1:0]   hit;
    logic                 violation;

    // A region with base > limit cannot satisfy both bounds, so it never hits.
    generate
        for (genvar gi = 0; gi < REGIONS; gi++) begin : g_hit
            assign hit[gi] = enable_reg[gi]
                           && (bus_addr >= base_reg[gi])
                           && (bus_addr <= limit_reg[gi]);
        end
    endgenerate

    assign violation = bus_valid && (|hit) && (bus_write || (|(hit & rdprot_reg)));

    always_comb begin
        state_next = state_reg;
        set_next   = 1'b0;
        addr_next  = addr_reg;
        write_next = write_reg;
        count_next = count_reg;
        if (violation && (count_reg != 8'hFF)) begin
            count_next = count_reg + 8'd1;
        end
        case (state_reg)
            IDLE: begin
                if (violation) begin
                    state_next = FAULT;
                    set_next   = 1'b1;
                    addr_next  = bus_addr;
                    write_next = bus_write;
                end
            end
            FAULT: begin
                // Only an acknowledged fault lets a new violation be reported.
                if (fault_ack) begin
                    if (violation) begin
                        set_next   = 1'b1;
                        addr_next  = bus_addr;
                        write_next = bus_write;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg  <= IDLE;
            set_reg    <= 1'b0;
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            count_reg  <= 8'd0;
            enable_reg <= '0;
            rdprot_reg <= '0;
            for (int i = 0; i < REGIONS; i++) begin
                base_reg[i]  <= '0;
                limit_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            set_reg   <= set_next;
            addr_reg  <= addr_next;
            write_reg <= write_next;
            count_reg <= count_next;
            if (cfg_we) begin
                base_reg[cfg_region]   <= cfg_base;
                limit_reg[cfg_region]  <= cfg_limit;
                enable_reg[cfg_region] <= cfg_enable;
                rdprot_reg[cfg_region] <= cfg_rdprot;
            end
        end
    end

    assign violation_set   = set_reg;
    assign violation_addr  = addr_reg;
    assign violation_write = write_reg;
    assign fault_pending   = (state_reg == FAULT);
    assign violation_count = count_reg;

endmodule

// File: tb/tb_protect_checker.sv
// Directed bench for protect_checker: a table of single-cycle vectors followed
// by hand sequences for saturation, asynchronous reset and back-to-back faults.
module tb_protect_checker;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cfg_we;
    logic [1:0]  cfg_region;
    logic [31:0] cfg_base, cfg_limit;
    logic        cfg_enable, cfg_rdprot;
    logic        bus_valid, bus_write;
    logic [31:0] bus_addr;
    logic        fault_ack;
    logic        violation_set;
    logic [31:0] violation_addr;
    logic        violation_write;
    logic        fault_pending;
    logic [7:0]  violation_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    protect_checker #(.BUS_WIDTH(32), .REGIONS(4)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .cfg_we          (cfg_we),
        .cfg_region      (cfg_region),
        .cfg_base        (cfg_base),
        .cfg_limit       (cfg_limit),
        .cfg_enable      (cfg_enable),
        .cfg_rdprot      (cfg_rdprot),
        .bus_valid       (bus_valid),
        .bus_write       (bus_write),
        .bus_addr        (bus_addr),
        .fault_ack       (fault_ack),
        .violation_set   (violation_set),
        .violation_addr  (violation_addr),
        .violation_write (violation_write),
        .fault_pending   (fault_pending),
        .violation_count (violation_count)
    );

    typedef struct {
        logic        we;
        logic [1:0]  rg;
        logic [31:0] base;
        logic [31:0] limit;
        logic        en;
        logic        rdp;
        logic        valid;
        logic        wr;
        logic [31:0] addr;
        logic        ack;
        logic        e_set;
        logic [31:0] e_addr;
        logic        e_w;
        logic        e_pend;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_set, input logic [31:0] e_addr,
                           input logic e_w, input logic e_pend, input logic [7:0] e_cnt);
        chk({tag, ".set"},   {31'd0, violation_set},   {31'd0, e_set});
        chk({tag, ".addr"},  violation_addr,           e_addr);
        chk({tag, ".write"}, {31'd0, violation_write}, {31'd0, e_w});
        chk({tag, ".pend"},  {31'd0, fault_pending},   {31'd0, e_pend});
        chk({tag, ".count"}, {24'd0, violation_count}, {24'd0, e_cnt});
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_region = 0; cfg_base = 0; cfg_limit = 0;
        cfg_enable = 0; cfg_rdprot = 0;
        bus_valid = 0; bus_write = 0; bus_addr = 0; fault_ack = 0;
    endtask

    task automatic bus_cycle(input logic valid, input logic wr, input logic [31:0] addr,
                             input logic ack);
        cfg_we = 0; bus_valid = valid; bus_write = wr; bus_addr = addr; fault_ack = ack;
        @(posedge clk); #1;
    endtask

    initial begin
        //                 we rg base        limit       en rdp vl wr addr        ack | set addr        w  p  cnt
        vecs[0]  = '{1, 0, 32'h1000, 32'h1FFF, 1, 0, 0, 0, 32'h0,    0,  0, 32'h0,    0, 0, 8'd0};
        vecs[1]  = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h1000, 0,  1, 32'h1000, 1, 1, 8'd1};
        vecs[2]  = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h1004, 0,  0, 32'h1000, 1, 1, 8'd2};
        vecs[3]  = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h1008, 1,  1, 32'h1008, 1, 1, 8'd3};
        vecs[4]  = '{0, 0, 32'h0,    32'h0,    0, 0, 0, 0, 32'h0,    1,  0, 32'h1008, 1, 0, 8'd3};
        vecs[5]  = '{0, 0, 32'h0,    32'h0,    0, 0, 0, 0, 32'h0,    1,  0, 32'h1008, 1, 0, 8'd3};
        vecs[6]  = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 0, 32'h1800, 0,  0, 32'h1008, 1, 0, 8'd3};
        vecs[7]  = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h2000, 0,  0, 32'h1008, 1, 0, 8'd3};
        vecs[8]  = '{1, 0, 32'h1000, 32'h1FFF, 1, 1, 1, 0, 32'h1FFF, 0,  0, 32'h1008, 1, 0, 8'd3};
        vecs[9]  = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 0, 32'h1FFF, 0,  1, 32'h1FFF, 0, 1, 8'd4};
        vecs[10] = '{0, 0, 32'h0,    32'h0,    0, 0, 0, 0, 32'h0,    1,  0, 32'h1FFF, 0, 0, 8'd4};
        vecs[11] = '{1, 0, 32'h0,    32'h0,    0, 0, 0, 0, 32'h0,    0,  0, 32'h1FFF, 0, 0, 8'd4};
        vecs[12] = '{1, 2, 32'h3000, 32'h2000, 1, 0, 0, 0, 32'h0,    0,  0, 32'h1FFF, 0, 0, 8'd4};
        vecs[13] = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h2800, 0,  0, 32'h1FFF, 0, 0, 8'd4};
        vecs[14] = '{1, 1, 32'h0,    32'hFF,   1, 0, 1, 1, 32'h10,   0,  0, 32'h1FFF, 0, 0, 8'd4};
        vecs[15] = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h10,   0,  1, 32'h10,   1, 1, 8'd5};
        vecs[16] = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'hFF,   0,  0, 32'h10,   1, 1, 8'd6};
        vecs[17] = '{0, 0, 32'h0,    32'h0,    0, 0, 1, 1, 32'h100,  1,  0, 32'h10,   1, 0, 8'd6};

        idle_inputs();
        nreset = 0;
        #2;
        chk_all("reset", 0, 32'h0, 0, 0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            cfg_we = vecs[i].we; cfg_region = vecs[i].rg;
            cfg_base = vecs[i].base; cfg_limit = vecs[i].limit;
            cfg_enable = vecs[i].en; cfg_rdprot = vecs[i].rdp;
            bus_valid = vecs[i].valid; bus_write = vecs[i].wr;
            bus_addr = vecs[i].addr; fault_ack = vecs[i].ack;
            @(posedge clk); #1;
            $display("vec %0d: set=%0b addr=%h w=%0b pend=%0b cnt=%0d", i, violation_set,
                     violation_addr, violation_write, fault_pending, violation_count);
            chk_all($sformatf("vec%0d", i), vecs[i].e_set, vecs[i].e_addr, vecs[i].e_w,
                    vecs[i].e_pend, vecs[i].e_cnt);
        end

        // Saturation: 300 unacknowledged violating writes into region 1.
        for (int i = 0; i < 300; i++) bus_cycle(1, 1, 32'h10, 0);
        $display("saturate: cnt=%0d pend=%0b addr=%h", violation_count, fault_pending, violation_addr);
        chk_all("saturate", 0, 32'h10, 1, 1, 8'd255);

        // Asynchronous reset in FAULT with a violating beat on the bus.
        bus_valid = 1; bus_write = 1; bus_addr = 32'h10; fault_ack = 0;
        #2;
        nreset = 0;
        #1;
        $display("async reset: set=%0b pend=%0b cnt=%0d", violation_set, fault_pending, violation_count);
        chk_all("async_rst", 0, 32'h0, 0, 0, 8'd0);
        @(posedge clk);
        @(negedge clk);
        bus_addr = 32'h1000;
        nreset = 1;
        @(posedge clk); #1;
        $display("post reset 0x1000: set=%0b cnt=%0d", violation_set, violation_count);
        chk_all("post_rst1", 0, 32'h0, 0, 0, 8'd0);
        bus_cycle(1, 1, 32'h10, 0);
        $display("post reset 0x10: set=%0b cnt=%0d", violation_set, violation_count);
        chk_all("post_rst2", 0, 32'h0, 0, 0, 8'd0);

        // Reconfigure region 0, then back-to-back acknowledged violations.
        cfg_we = 1; cfg_region = 0; cfg_base = 32'h1000; cfg_limit = 32'h1FFF;
        cfg_enable = 1; cfg_rdprot = 0; bus_valid = 0; fault_ack = 0;
        @(posedge clk); #1;
        bus_cycle(1, 1, 32'h1000, 0);
        $display("reconfig write: set=%0b addr=%h cnt=%0d", violation_set, violation_addr, violation_count);
        chk_all("reconf", 1, 32'h1000, 1, 1, 8'd1);
        bus_cycle(1, 1, 32'h1004, 1);
        $display("b2b 1: set=%0b addr=%h cnt=%0d", violation_set, violation_addr, violation_count);
        chk_all("b2b1", 1, 32'h1004, 1, 1, 8'd2);
        bus_cycle(1, 1, 32'h1008, 1);
        $display("b2b 2: set=%0b addr=%h cnt=%0d", violation_set, violation_addr, violation_count);
        chk_all("b2b2", 1, 32'h1008, 1, 1, 8'd3);
        bus_cycle(0, 0, 32'h0, 1);
        $display("final ack: set=%0b pend=%0b", violation_set, fault_pending);
        chk_all("final_ack", 0, 32'h1008, 1, 0, 8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
